avmm_cmd_master: RTL and testbench
==================================

AVMM_CMD_MASTER -- requirements
Module: avmm_cmd_master

Interface
REQ-001 SHALL have parameter AW, default 12: Avalon-MM word address width.
REQ-002 SHALL have parameter DW, default 32: data width; byteenable width DW/8.
REQ-003 SHALL have parameter BCW, default 5: burstcount width; maximum burst 16 beats.
REQ-004 SHALL have parameter TO_CYCLES, default 255: bus stall timeout in clk cycles.
REQ-005 SHALL have ports, in order:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset, sampled on rising clk.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted this cycle when both cmd_valid and cmd_ready are high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AW  start word address.
- cmd_len  in  BCW  beat count 1..16; 0 treated as 1, >16 clamped to 16.
- cmd_byteenable  in  DW/8  byteenable for all beats.
- wr_data  in  DW  write beat data.
- wr_valid  in  1  write beat available.
- wr_ready  out  1  write beat consumed this cycle.
- rd_data  out  DW  read beat data.
- rd_valid  out  1  read beat valid, one cycle per beat.
- done  out  1  one-cycle pulse, command completed.
- err_timeout  out  1  one-cycle pulse, command aborted on timeout.
- busy  out  1  high in any state other than IDLE.
- avm_address, avm_read, avm_write, avm_burstcount, avm_writedata, avm_byteenable  out  AW/1/1/BCW/DW/DW/8  Avalon-MM master outputs, all registered.
- avm_waitrequest, avm_readdata, avm_readdatavalid  in  1/DW/1  Avalon-MM master inputs.

Function
REQ-006 SHALL implement FSM states IDLE, WRITE, READ_REQ, READ_DATA.
REQ-007 cmd_ready SHALL be 1 only in IDLE; on acceptance, addr, len (after 0/clamp rule), byteenable and direction SHALL be latched, and the next state SHALL be WRITE or READ_REQ.
REQ-008 avm_address, avm_burstcount and avm_byteenable SHALL hold the latched values, unchanged, from the first asserted beat to command end.
REQ-009 WRITE: while avm_write=0 and wr_valid=1, SHALL pulse wr_ready for that cycle, load wr_data into avm_writedata, and assert avm_write next cycle.
REQ-010 WRITE: a beat completes on a cycle with avm_write=1 and avm_waitrequest=0; avm_write SHALL drop next cycle and the remaining count SHALL decrement.
- On the last beat: done pulse next cycle, then IDLE.
- Throughput: at most one beat per two cycles.
REQ-011 WRITE: wr_ready SHALL never be high while avm_write=1; avm_writedata SHALL be stable while avm_waitrequest=1.
REQ-012 READ_REQ: avm_read SHALL be asserted in the cycle after entry and held until sampled with avm_waitrequest=0, then deasserted next cycle; next state READ_DATA.
REQ-013 READ_DATA: each cycle with avm_readdatavalid=1 SHALL register avm_readdata to rd_data with rd_valid=1 exactly one cycle later.
- After the len-th beat: done pulse coincides with the last rd_valid, then IDLE.
- avm_readdatavalid in READ_REQ or IDLE SHALL be ignored.
REQ-014 Timeout counter SHALL clear on state entry and on every completed beat, word-accept or readdatavalid.
- It SHALL increment each cycle in WRITE with avm_write=1 and avm_waitrequest=1, in READ_REQ, and in READ_DATA.
- It SHALL NOT increment in WRITE while waiting for wr_valid.
REQ-015 When the counter reaches TO_CYCLES, the block SHALL deassert avm_read/avm_write, pulse err_timeout (no done), and return to IDLE next cycle.
REQ-016 done and err_timeout SHALL never be high in the same cycle.
REQ-017 A new command SHALL be accepted no earlier than the cycle after the done or err_timeout pulse.

Reset
REQ-018 On reset, the FSM SHALL go to IDLE and the counters SHALL clear.
REQ-019 On reset, all outputs SHALL be 0, including avm_address, avm_burstcount, avm_writedata and rd_data, with one exception: cmd_ready SHALL be 1 from the first cycle after reset is released.
REQ-020 Reset asserted mid-burst SHALL abort the command at the next clk edge with no done and no err_timeout pulse.

Verification
REQ-021 Single write: cmd addr=0x010, len=1, be=0xF, wr_data=0x0000FEFE, waitrequest low -> one avm_write cycle with address 0x010, burstcount 1, writedata 0xFEFE; done 1 cycle later.
REQ-022 Burst write with stall: len=4, data 1..4, waitrequest high 3 cycles on beat 2 -> writedata held during the stall; 4 wr_ready pulses; beats in order 1..4; burstcount stays 4.
REQ-023 Burst read: addr=0x100, len=3, slave returns 0xA,0xB,0xC with gaps of 0,2,1 cycles -> rd_valid x3 with 0xA,0xB,0xC each 1 cycle after readdatavalid; done with the 3rd rd_valid.
REQ-024 Timeout: read with waitrequest held high, TO_CYCLES=8 -> avm_read drops and err_timeout pulses after 8 stalled cycles; no done; cmd_ready=1 next cycle.
REQ-025 Length edge: cmd_len=0 -> burstcount 1; cmd_len=20 -> burstcount 16.
REQ-026 Reset mid-burst read after beat 1 of 4 -> all outputs 0 next cycle; no done; a later read of len=1 completes normally.

Source files
------------

// File: rtl/avmm_cmd_master.sv
// rtl/avmm_cmd_master.sv - Avalon-MM burst command master with stall timeout
// Turns one command into a read or write burst; writes pace one beat per two cycles.
module avmm_cmd_master #(
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter int BCW       = 5,
  parameter int TO_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [BCW-1:0]  cmd_len,
  input  logic [DW/8-1:0] cmd_byteenable,
  input  logic [DW-1:0]   wr_data,
  input  logic            wr_valid,
  output logic            wr_ready,
  output logic [DW-1:0]   rd_data,
  output logic            rd_valid,
  output logic            done,
  output logic            err_timeout,
  output logic            busy,
  output logic [AW-1:0]   avm_address,
  output logic            avm_read,
  output logic            avm_write,
  output logic [BCW-1:0]  avm_burstcount,
  output logic [DW-1:0]   avm_writedata,
  output logic [DW/8-1:0] avm_byteenable,
  input  logic            avm_waitrequest,
  input  logic [DW-1:0]   avm_readdata,
  input  logic            avm_readdatavalid
);

  typedef enum logic [1:0] {IDLE, WRITE, READ_REQ, READ_DATA} state_t;

  localparam int             TW        = $clog2(TO_CYCLES + 1);
  localparam logic [BCW-1:0] MAX_BURST = BCW'(16);
  localparam logic [TW-1:0]  TO_LAST   = TW'(TO_CYCLES - 1);

  state_t         state, state_nxt;
  logic [BCW-1:0] remaining;
  logic [BCW-1:0] len_eff;
  logic [TW-1:0]  to_cnt;
  logic           finishing, accept, wr_beat, rd_accept, rd_beat, to_count, to_hit;

  always_comb begin
    if (cmd_len == '0)
      len_eff = BCW'(1);
    else if (cmd_len > MAX_BURST)
      len_eff = MAX_BURST;
    else
      len_eff = cmd_len;
  end

  // A done/err pulse keeps the FSM out of IDLE for that cycle so no command overlaps it.
  assign finishing = done | err_timeout;
  assign accept    = cmd_valid & cmd_ready;
  assign wr_beat   = (state == WRITE) & avm_write & ~avm_waitrequest;
  assign rd_accept = (state == READ_REQ) & avm_read & ~avm_waitrequest;
  assign rd_beat   = (state == READ_DATA) & ~finishing & avm_readdatavalid;
  assign to_count  = ~finishing &
                     (((state == WRITE) & avm_write & avm_waitrequest) |
                      ((state == READ_REQ) & ~rd_accept) |
                      ((state == READ_DATA) & ~avm_readdatavalid));
  assign to_hit    = to_count & (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = cmd_write ? WRITE : READ_REQ;
      WRITE:     if (finishing) state_nxt = IDLE;
      READ_REQ:  if (finishing) state_nxt = IDLE;
                 else if (rd_accept) state_nxt = READ_DATA;
      READ_DATA: if (finishing) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    cmd_ready = (state == IDLE) & ~reset;
    wr_ready  = (state == WRITE) & ~reset & ~finishing & ~avm_write &
                (remaining != '0) & wr_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avm_address    <= '0;
      avm_burstcount <= '0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      rd_data        <= '0;
      rd_valid       <= 1'b0;
      done           <= 1'b0;
      err_timeout    <= 1'b0;
      remaining      <= '0;
      to_cnt         <= '0;
    end else begin
      rd_valid    <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      if (accept) begin
        avm_address    <= cmd_addr;
        avm_burstcount <= len_eff;
        avm_byteenable <= cmd_byteenable;
        remaining      <= len_eff;
        avm_read       <= ~cmd_write;
      end
      if (wr_ready) begin
        avm_writedata <= wr_data;
        avm_write     <= 1'b1;
      end
      if (wr_beat) begin
        avm_write <= 1'b0;
        remaining <= remaining - BCW'(1);
        if (remaining == BCW'(1)) done <= 1'b1;
      end
      if (rd_accept) avm_read <= 1'b0;
      if (rd_beat) begin
        rd_data   <= avm_readdata;
        rd_valid  <= 1'b1;
        remaining <= remaining - BCW'(1);
        if (remaining == BCW'(1)) done <= 1'b1;
      end
      if (wr_beat | wr_ready | rd_accept | rd_beat | (state_nxt != state))
        to_cnt <= '0;
      else if (to_count)
        to_cnt <= to_cnt + TW'(1);
      if (to_hit) begin
        avm_read    <= 1'b0;
        avm_write   <= 1'b0;
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_avmm_cmd_master.sv
// tb/tb_avmm_cmd_master.sv - self-checking bench for avmm_cmd_master
// Bench-side Avalon slave with scripted or random stalls and read gaps; queues hold expected beats.
module tb_avmm_cmd_master;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int BEW = DW / 8;
  localparam int BCW = 5;
  localparam int TO  = 8;

  logic           clk = 1'b0;
  logic           reset, cmd_valid, cmd_ready, cmd_write, wr_valid, wr_ready;
  logic           rd_valid, done, err_timeout, busy;
  logic [AW-1:0]  cmd_addr, avm_address;
  logic [BCW-1:0] cmd_len, avm_burstcount;
  logic [BEW-1:0] cmd_byteenable, avm_byteenable;
  logic [DW-1:0]  wr_data, rd_data, avm_writedata, avm_readdata;
  logic           avm_read, avm_write, avm_waitrequest, avm_readdatavalid;

  avmm_cmd_master #(.AW(AW), .DW(DW), .BCW(BCW), .TO_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_byteenable(cmd_byteenable),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err_timeout(err_timeout),
    .busy(busy), .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_burstcount(avm_burstcount), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit             w;
    logic [AW-1:0]  addr;
    logic [BCW-1:0] len;
    logic [BEW-1:0] be;
    int             exp_bc;
  } vec_t;

  int             n_checks = 0;
  int             n_fail = 0;
  int             cyc = 0;
  bit             cmd_pending, c_write;
  logic [AW-1:0]  c_addr;
  logic [BCW-1:0] c_len;
  logic [BEW-1:0] c_be;
  logic [AW-1:0]  exp_addr;
  logic [BCW-1:0] exp_bc;
  logic [BEW-1:0] exp_be;
  int             exp_eff;
  int             stall_max, stall_left, wr_gap_max, wgap_left;
  int             stall_plan[$], gap_plan[$], rgap[$];
  logic [DW-1:0]  wdata_plan[$], rdata_plan[$], rdat[$], wq[$], wexp[$], rexp[$];
  bit             rd_data_phase, prev_real_rdv, real_rdv, prev_wstall;
  logic [DW-1:0]  prev_wdata;
  int             beats_seen, wr_seen, rdv_seen, done_seen, err_seen, read_hi;
  int             acc_cyc, done_cyc, err_cyc, last_beat_cyc, last_rdv_cyc;

  function automatic int eff_len(input int l);
    if (l == 0) return 1;
    if (l > 16) return 16;
    return l;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_wr_ready"}, wr_ready, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err_timeout"}, err_timeout, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_avm_address"}, avm_address, 0);
    check({tag, "_avm_read"}, avm_read, 0);
    check({tag, "_avm_write"}, avm_write, 0);
    check({tag, "_avm_burstcount"}, avm_burstcount, 0);
    check({tag, "_avm_writedata"}, avm_writedata, 0);
    check({tag, "_avm_byteenable"}, avm_byteenable, 0);
  endtask

  // One clock: drive all inputs after negedge, then sample and score 1 time unit later.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    cmd_valid = cmd_pending;
    if (cmd_pending) begin
      cmd_write = c_write; cmd_addr = c_addr; cmd_len = c_len; cmd_byteenable = c_be;
    end else begin
      cmd_write = 1'($urandom()); cmd_addr = AW'($urandom());
      cmd_len = BCW'($urandom()); cmd_byteenable = BEW'($urandom());
    end
    if (avm_read || avm_write) begin
      if (stall_left < 0)
        stall_left = (stall_plan.size() > 0) ? stall_plan.pop_front()
                                             : int'($urandom_range(0, stall_max));
      if (stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        avm_waitrequest = 1'b0;
        stall_left = -1;
      end
    end else begin
      avm_waitrequest = 1'($urandom());
    end
    real_rdv = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata = DW'($urandom());
    if (rgap.size() > 0) begin
      if (rgap[0] == 0) begin
        void'(rgap.pop_front());
        avm_readdata = rdat.pop_front();
        avm_readdatavalid = 1'b1;
        real_rdv = 1'b1;
        rexp.push_back(avm_readdata);
      end else begin
        rgap[0] = rgap[0] - 1;
      end
    end else if (!c_write && !rd_data_phase) begin
      avm_readdatavalid = 1'($urandom());
    end
    if (wq.size() > 0 && wgap_left == 0) begin
      wr_valid = 1'b1;
      wr_data = wq[0];
    end else begin
      wr_valid = 1'b0;
      wr_data = DW'($urandom());
      if (wgap_left > 0) wgap_left--;
    end
    #1;
    if (done) begin done_seen++; done_cyc = cyc; end
    if (err_timeout) begin err_seen++; err_cyc = cyc; end
    if (!reset) begin
      check("ready_vs_busy", cmd_ready, !busy);
      check("done_and_err", done & err_timeout, 0);
      check("wr_ready_while_write", wr_ready & avm_write, 0);
      check("rd_valid_timing", rd_valid, prev_real_rdv);
      if (avm_write && prev_wstall) check("wdata_stable", avm_writedata, prev_wdata);
      if (err_timeout) check("bus_idle_on_err", avm_read | avm_write, 0);
      if (rd_data_phase) check("read_dropped", avm_read, 0);
      if (wr_ready) begin
        check("wr_ready_needs_valid", wr_valid, 1);
        wr_seen++;
        if (wq.size() > 0) void'(wq.pop_front());
        wgap_left = int'($urandom_range(0, wr_gap_max));
      end
      if (avm_write && !avm_waitrequest) begin
        beats_seen++;
        last_beat_cyc = cyc;
        check("wr_address", avm_address, exp_addr);
        check("wr_burstcount", avm_burstcount, exp_bc);
        check("wr_byteenable", avm_byteenable, exp_be);
        if (wexp.size() > 0) check("wr_beat_data", avm_writedata, wexp.pop_front());
      end
      if (avm_read && !avm_waitrequest && !rd_data_phase) begin
        check("rd_address", avm_address, exp_addr);
        check("rd_burstcount", avm_burstcount, exp_bc);
        check("rd_byteenable", avm_byteenable, exp_be);
        rd_data_phase = 1'b1;
        for (int i = 0; i < exp_eff; i++) begin
          rgap.push_back((gap_plan.size() > 0) ? gap_plan.pop_front() : int'($urandom_range(0, 3)));
          rdat.push_back((rdata_plan.size() > 0) ? rdata_plan.pop_front() : DW'($urandom()));
        end
      end
      if (rd_valid) begin
        rdv_seen++;
        last_rdv_cyc = cyc;
        if (rexp.size() > 0) check("rd_data", rd_data, rexp.pop_front());
      end
      if (avm_read) read_hi++;
      if (cmd_valid && cmd_ready) begin
        cmd_pending = 1'b0;
        acc_cyc = cyc;
      end
    end
    prev_wstall = avm_write && avm_waitrequest && !reset;
    prev_wdata = avm_writedata;
    prev_real_rdv = real_rdv && !reset;
  endtask

  task automatic start_cmd(input bit w, input logic [AW-1:0] a, input logic [BCW-1:0] l,
                           input logic [BEW-1:0] be, input int bc);
    logic [DW-1:0] d;
    c_write = w; c_addr = a; c_len = l; c_be = be; cmd_pending = 1'b1;
    exp_addr = a; exp_bc = BCW'(bc); exp_be = be; exp_eff = bc;
    beats_seen = 0; wr_seen = 0; rdv_seen = 0; done_seen = 0; err_seen = 0; read_hi = 0;
    acc_cyc = 0; done_cyc = 0; err_cyc = 0; last_beat_cyc = 0; last_rdv_cyc = 0;
    stall_left = -1; rd_data_phase = 1'b0; prev_wstall = 1'b0;
    wq.delete(); wexp.delete(); rexp.delete(); rgap.delete(); rdat.delete();
    wgap_left = int'($urandom_range(0, wr_gap_max));
    if (w) begin
      for (int i = 0; i < bc; i++) begin
        d = (wdata_plan.size() > 0) ? wdata_plan.pop_front() : DW'($urandom());
        wq.push_back(d);
        wexp.push_back(d);
      end
    end
  endtask

  task automatic finish_cmd(input bit expect_to);
    for (int t = 0; t < 500 && (done_seen + err_seen) == 0; t++) cycle();
    check("cmd_completes", (done_seen + err_seen) != 0, 1);
    cycle();
    check("ready_after_end", cmd_ready, 1);
    check("single_end_pulse", done_seen + err_seen, 1);
    if (expect_to) begin
      check("timeout_no_done", done_seen, 0);
      check("timeout_err", err_seen, 1);
      if (!c_write) begin
        check("timeout_cycle", err_cyc - acc_cyc, TO + 1);
        check("read_stall_cycles", read_hi, TO);
      end
    end else if (c_write) begin
      check("write_beats", beats_seen, exp_eff);
      check("wr_ready_pulses", wr_seen, exp_eff);
      check("done_after_last_beat", done_cyc - last_beat_cyc, 1);
      check("write_no_err", err_seen, 0);
    end else begin
      check("read_beats", rdv_seen, exp_eff);
      check("done_with_last_rdv", done_cyc, last_rdv_cyc);
      check("read_no_err", err_seen, 0);
    end
  endtask

  task automatic run_cmd(input bit w, input logic [AW-1:0] a, input logic [BCW-1:0] l,
                         input logic [BEW-1:0] be, input int bc);
    start_cmd(w, a, l, be, bc);
    finish_cmd(1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required earlier finish", cyc);
    $fatal(1);
  end

  initial begin
    vec_t vecs[9];
    bit            rw;
    logic [BCW-1:0] rl;

    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_byteenable = '0; wr_data = '0; wr_valid = 1'b0; avm_waitrequest = 1'b0;
    avm_readdata = '0; avm_readdatavalid = 1'b0;
    cmd_pending = 1'b0; c_write = 1'b0; stall_max = 0; wr_gap_max = 0; stall_left = -1;
    wgap_left = 0; rd_data_phase = 1'b0; prev_real_rdv = 1'b0; prev_wstall = 1'b0;
    exp_eff = 1; exp_addr = '0; exp_bc = '0; exp_be = '0;

    vecs[0] = '{1'b1, 12'h010, 5'd1,  4'hF, 1};
    vecs[1] = '{1'b0, 12'h100, 5'd3,  4'hF, 3};
    vecs[2] = '{1'b1, 12'h3FF, 5'd0,  4'h5, 1};
    vecs[3] = '{1'b0, 12'h020, 5'd0,  4'hA, 1};
    vecs[4] = '{1'b1, 12'h007, 5'd20, 4'hF, 16};
    vecs[5] = '{1'b0, 12'hABC, 5'd31, 4'h3, 16};
    vecs[6] = '{1'b1, 12'h055, 5'd16, 4'hC, 16};
    vecs[7] = '{1'b0, 12'hFFF, 5'd17, 4'hF, 16};
    vecs[8] = '{1'b1, 12'h200, 5'd2,  4'h1, 2};

    cycle();
    cycle();
    check_all_zero("por");
    reset = 1'b0;
    cycle();
    check("ready_after_reset", cmd_ready, 1);

    // Single write, no stall: write beat one cycle after wr_ready, done one cycle later.
    stall_plan = '{0}; wdata_plan = '{32'h0000FEFE}; wr_gap_max = 0;
    run_cmd(1'b1, 12'h010, 5'd1, 4'hF, 1);
    check("single_write_latency", done_cyc - acc_cyc, 3);

    // Burst write with a 3-cycle stall on beat 2.
    stall_plan = '{0, 3, 0, 0}; wdata_plan = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_cmd(1'b1, 12'h044, 5'd4, 4'hF, 4);

    // Burst read with return gaps 0,2,1.
    stall_plan = '{0}; gap_plan = '{0, 2, 1}; rdata_plan = '{32'hA, 32'hB, 32'hC};
    run_cmd(1'b0, 12'h100, 5'd3, 4'hF, 3);
    check("burst_read_done_cycle", done_cyc - acc_cyc, 8);

    // Read stalled forever: times out after TO stalled cycles.
    stall_plan = '{100};
    start_cmd(1'b0, 12'h040, 5'd2, 4'hF, 2);
    finish_cmd(1'b1);

    // Write stalled on beat 2: one beat lands, then timeout.
    stall_plan = '{0, 50}; wr_gap_max = 1;
    start_cmd(1'b1, 12'h0C0, 5'd3, 4'h6, 3);
    finish_cmd(1'b1);
    check("write_timeout_beats", beats_seen, 1);

    // Table of command shapes under random stalls and gaps.
    stall_max = 5; wr_gap_max = 2;
    foreach (vecs[i]) run_cmd(vecs[i].w, vecs[i].addr, vecs[i].len, vecs[i].be, vecs[i].exp_bc);

    // Reset after first beat of a 4-beat read.
    stall_plan = '{0}; gap_plan = '{0, 1, 1, 1};
    start_cmd(1'b0, 12'h300, 5'd4, 4'hF, 4);
    for (int t = 0; t < 50 && rdv_seen == 0; t++) cycle();
    check("abort_first_beat", rdv_seen, 1);
    reset = 1'b1;
    cycle();
    cycle();
    check_all_zero("abort");
    check("abort_no_done", done_seen, 0);
    check("abort_no_err", err_seen, 0);
    rgap.delete(); rdat.delete(); rexp.delete(); gap_plan.delete();
    reset = 1'b0;
    cycle();
    check("ready_after_abort", cmd_ready, 1);
    run_cmd(1'b0, 12'h301, 5'd1, 4'hF, 1);

    // Randomized commands scored by the queue model.
    for (int k = 0; k < 20; k++) begin
      rw = 1'($urandom());
      rl = BCW'($urandom());
      run_cmd(rw, AW'($urandom()), rl, BEW'($urandom()), eff_len(int'(rl)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
